// File: rtl/div_result_bcd_if.sv
// ---------------------------------------------------------------------------
// div_result_bcd_if
//   Handshake and data bundle between the SRT divider, the BCD converter
//   and the display/VIO stage.
//
//   Upstream side : in_valid, in_ready, quotient[31:0], remainder[32:0],
//                   div_zero
//   Downstream side: out_valid, out_ready, quot_bcd[39:0], rem_bcd[39:0],
//                   rem_ovf, err_dbz
//   Status         : busy
//
//   The slave modport is the converter's view. The master modport is the
//   view of whatever surrounds it: the divider on the input side and the
//   display stage on the output side.
// ---------------------------------------------------------------------------
interface div_result_bcd_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] quotient;
    logic [32:0] remainder;
    logic        div_zero;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] quot_bcd;
    logic [39:0] rem_bcd;
    logic        rem_ovf;
    logic        err_dbz;
    logic        busy;

    modport slave (
        input  in_valid, quotient, remainder, div_zero, out_ready,
        output in_ready, out_valid, quot_bcd, rem_bcd, rem_ovf, err_dbz, busy
    );

    modport master (
        output in_valid, quotient, remainder, div_zero, out_ready,
        input  in_ready, out_valid, quot_bcd, rem_bcd, rem_ovf, err_dbz, busy
    );
endinterface

// File: rtl/div_result_bcd.sv
// ---------------------------------------------------------------------------
// div_result_bcd
//   Converts one divider result (32-bit quotient, 33-bit remainder) into two
//   10-digit packed BCD numbers using iterative double-dabble. The quotient is
//   converted first, then the remainder, each taking 32 cycles. The result is
//   then presented with a valid/ready handshake. One transaction is in flight
//   at a time.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : div_result_bcd_if.slave
//            in_valid/in_ready/quotient/remainder/div_zero - capture side
//            out_valid/out_ready/quot_bcd/rem_bcd/rem_ovf/err_dbz - result side
//            busy - high while either conversion phase is running
// ---------------------------------------------------------------------------
module div_result_bcd (
    input  logic             clk,
    input  logic             rst,
    div_result_bcd_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] shift_reg;
    logic [31:0] rem_hold;
    logic [39:0] bcd_acc;
    logic [39:0] bcd_next;
    logic [4:0]  bit_cnt;
    logic [39:0] quot_bcd_q;
    logic [39:0] rem_bcd_q;
    logic        rem_ovf_q;
    logic        err_dbz_q;

    logic        in_ready_c;
    logic        out_valid_c;
    logic        busy_c;
    logic        accept;
    logic        last_iter;

    logic [3:0]  digit_adj;
    logic        digit_carry;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_iter = (bit_cnt == 5'd31);

    // State register. Reset in any state abandons the transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Each conversion phase ends on the
    // iteration where the counter reads 31, i.e. after exactly 32 iterations.
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = CONV_Q;
                end
            end
            CONV_Q: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_next = CONV_R;
                end
            end
            CONV_R: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble iteration: every digit >= 5 is corrected by +3, then
    // the whole {bcd, binary} pair shifts left by one. Doing the shift digit
    // by digit, the top bit of each corrected digit becomes bit 0 of the next
    // digit up, and the binary MSB enters digit 0. The carry out of digit 9 is
    // always zero because 2^32-1 fits in ten decimal digits.
    always_comb begin
        bcd_next    = '0;
        digit_adj   = '0;
        digit_carry = shift_reg[31];
        for (int i = 0; i < 10; i++) begin
            digit_adj = bcd_acc[i*4 +: 4];
            if (digit_adj >= 4'd5) begin
                digit_adj = digit_adj + 4'd3;
            end
            bcd_next[i*4 +: 4] = {digit_adj[2:0], digit_carry};
            digit_carry        = digit_adj[3];
        end
    end

    // Datapath. Inputs are captured only on the accepting edge. The remainder
    // is parked in rem_hold until the quotient phase finishes and then reloaded
    // into the shared shift register. Results persist until the next
    // conversion overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            rem_hold   <= '0;
            bcd_acc    <= '0;
            bit_cnt    <= '0;
            quot_bcd_q <= '0;
            rem_bcd_q  <= '0;
            rem_ovf_q  <= 1'b0;
            err_dbz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= bus.quotient;
                        rem_hold  <= bus.remainder[31:0];
                        rem_ovf_q <= bus.remainder[32];
                        err_dbz_q <= bus.div_zero;
                        bcd_acc   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                CONV_Q: begin
                    if (last_iter) begin
                        quot_bcd_q <= bcd_next;
                        shift_reg  <= rem_hold;
                        bcd_acc    <= '0;
                        bit_cnt    <= '0;
                    end else begin
                        shift_reg <= {shift_reg[30:0], 1'b0};
                        bcd_acc   <= bcd_next;
                        bit_cnt   <= bit_cnt + 5'd1;
                    end
                end
                CONV_R: begin
                    if (last_iter) begin
                        rem_bcd_q <= bcd_next;
                        bcd_acc   <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        shift_reg <= {shift_reg[30:0], 1'b0};
                        bcd_acc   <= bcd_next;
                        bit_cnt   <= bit_cnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.quot_bcd  = quot_bcd_q;
    assign bus.rem_bcd   = rem_bcd_q;
    assign bus.rem_ovf   = rem_ovf_q;
    assign bus.err_dbz   = err_dbz_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// ---------------------------------------------------------------------------
// tb_div_result_bcd
//   Self-checking bench for div_result_bcd. Every accepted transaction pushes
//   its expected result, computed by decimal arithmetic, onto a scoreboard
//   queue. An independent monitor pops and compares whenever the DUT hands a
//   result over. The stimulus process also checks handshake timing and the
//   reset and back-pressure behaviour.
// ---------------------------------------------------------------------------
module tb_div_result_bcd;

    typedef struct {
        logic [39:0] q;
        logic [39:0] r;
        logic        ovf;
        logic        dbz;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    div_result_bcd_if dut_if ();

    div_result_bcd dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a bounded wait is itself broken
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: plain decimal digit extraction
    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0]     res;
        longint unsigned x;
        res = '0;
        x   = longint'(v);
        for (int i = 0; i < 10; i++) begin
            res[i*4 +: 4] = 4'(x % 10);
            x             = x / 10;
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare every delivered result against the scoreboard head.
    // Sampled on the falling edge; the handshake completes on the next rise.
    always @(negedge clk) begin
        if (!rst && dut_if.out_valid === 1'b1 && dut_if.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quot_bcd", 64'(dut_if.quot_bcd), 64'(e.q));
                checkOutput("rem_bcd",  64'(dut_if.rem_bcd),  64'(e.r));
                checkOutput("rem_ovf",  64'(dut_if.rem_ovf),  64'(e.ovf));
                checkOutput("err_dbz",  64'(dut_if.err_dbz),  64'(e.dbz));
            end
        end
    end

    // Wait (bounded) for in_ready, present one transaction, push its expected
    // result at the accepting edge, then scramble the inputs to show that
    // post-accept changes are ignored.
    task automatic applyStimulus(input logic [31:0] q, input logic [32:0] r,
                                 input logic dz);
        int   k;
        exp_t e;
        k = 0;
        while (dut_if.in_ready !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (dut_if.in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end
        dut_if.quotient  = q;
        dut_if.remainder = r;
        dut_if.div_zero  = dz;
        dut_if.in_valid  = 1'b1;
        @(posedge clk);
        e.q   = to_bcd(q);
        e.r   = to_bcd(r[31:0]);
        e.ovf = r[32];
        e.dbz = dz;
        sb.push_back(e);
        #1;
        dut_if.in_valid  = 1'b0;
        dut_if.quotient  = $urandom;
        dut_if.remainder = {1'($urandom_range(0, 1)), 32'($urandom)};
        dut_if.div_zero  = 1'($urandom_range(0, 1));
        checkOutput("in_ready_fall", 64'(dut_if.in_ready), 64'd0);
        checkOutput("busy_rise",     64'(dut_if.busy),     64'd1);
    endtask

    // Count cycles from the accepting edge until out_valid; must be 64, with
    // in_ready low and busy high for the whole conversion.
    task automatic waitResult();
        int   k;
        logic held;
        k    = 0;
        held = 1'b1;
        while (dut_if.out_valid !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (dut_if.in_ready !== 1'b0) held = 1'b0;
            if (dut_if.out_valid !== 1'b1 && dut_if.busy !== 1'b1) held = 1'b0;
        end
        checkOutput("latency", 64'(k), 64'd64);
        checkOutput("in_ready_low_busy_high", 64'(held), 64'd1);
    endtask

    // Complete a result with out_ready already high: after the handshake edge
    // in_ready returns and out_valid drops.
    task automatic finishHandshake();
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_hs",  64'(dut_if.in_ready),  64'd1);
        checkOutput("out_valid_after_hs", 64'(dut_if.out_valid), 64'd0);
    endtask

    task automatic runOne(input logic [31:0] q, input logic [32:0] r, input logic dz);
        applyStimulus(q, r, dz);
        waitResult();
        finishHandshake();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"},  64'(dut_if.in_ready),  64'd1);
        checkOutput({tag, "_out_valid"}, 64'(dut_if.out_valid), 64'd0);
        checkOutput({tag, "_busy"},      64'(dut_if.busy),      64'd0);
        checkOutput({tag, "_quot_bcd"},  64'(dut_if.quot_bcd),  64'd0);
        checkOutput({tag, "_rem_bcd"},   64'(dut_if.rem_bcd),   64'd0);
        checkOutput({tag, "_rem_ovf"},   64'(dut_if.rem_ovf),   64'd0);
        checkOutput({tag, "_err_dbz"},   64'(dut_if.err_dbz),   64'd0);
    endtask

    initial begin
        logic [31:0] bp_q;
        logic [32:0] bp_r;
        logic        stable;
        int          k;

        errors            = 0;
        checks            = 0;
        rst               = 1'b1;
        dut_if.in_valid   = 1'b0;
        dut_if.quotient   = '0;
        dut_if.remainder  = '0;
        dut_if.div_zero   = 1'b0;
        dut_if.out_ready  = 1'b1;

        #1;
        checkResetState("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed transactions");
        runOne(32'd0, 33'd0, 1'b0);
        runOne(32'd123456789, 33'd42, 1'b0);
        checkOutput("q_123456789", 64'(dut_if.quot_bcd), 64'h0123456789);
        checkOutput("r_42",        64'(dut_if.rem_bcd),  64'h0000000042);
        runOne(32'hFFFF_FFFF, 33'h0_FFFF_FFFE, 1'b0);
        checkOutput("q_max", 64'(dut_if.quot_bcd), 64'h4294967295);
        checkOutput("r_max", 64'(dut_if.rem_bcd),  64'h4294967294);
        runOne(32'd5, 33'h1_0000_0007, 1'b1);
        checkOutput("r_ovf_digits", 64'(dut_if.rem_bcd), 64'h0000000007);
        runOne(32'd10, 33'd3, 1'b0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 10; i++) begin
            runOne(32'($urandom), {1'($urandom_range(0, 1)), 32'($urandom)},
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] back-pressure");
        bp_q = 32'($urandom);
        bp_r = {1'b0, 32'($urandom)};
        dut_if.out_ready = 1'b0;
        applyStimulus(bp_q, bp_r, 1'b1);
        waitResult();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            dut_if.in_valid = ~dut_if.in_valid;
            dut_if.quotient = $urandom;
            if (dut_if.out_valid !== 1'b1 || dut_if.in_ready !== 1'b0 ||
                dut_if.quot_bcd !== to_bcd(bp_q) || dut_if.rem_bcd !== to_bcd(bp_r[31:0]) ||
                dut_if.err_dbz !== 1'b1 || dut_if.busy !== 1'b0) begin
                stable = 1'b0;
            end
        end
        checkOutput("bp_stable", 64'(stable), 64'd1);
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        finishHandshake();

        $display("[TB] reset during quotient conversion");
        applyStimulus(32'd777, 33'h1_0000_0001, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", 64'(dut_if.busy), 64'd1);
        rst = 1'b1;
        #1;
        sb.delete();
        checkResetState("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        runOne(32'd99, 33'd1, 1'b0);
        checkOutput("q_99", 64'(dut_if.quot_bcd), 64'h0000000099);
        checkOutput("r_1",  64'(dut_if.rem_bcd),  64'h0000000001);

        k = 0;
        while (sb.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Sequential binary-to-BCD converter that sits directly downstream of the 32-bit SRT divider. It captures one quotient/remainder pair per transaction and converts each to 10 packed BCD digits using iterative double-dabble (shift-add-3). It presents both results with a valid/ready handshake for the display/VIO stage. One conversion runs at a time; fixed latency, no pipelining.

## Interface
- No parameters; widths fixed: 32-bit quotient, 33-bit remainder, 10 BCD digits (40 bits) per result.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  quotient/remainder/div_zero valid.
- in_ready  output  1  block can accept a transaction (high only in IDLE).
- quotient  input  32  divider quotient, unsigned.
- remainder  input  33  divider remainder; bit 32 normally 0.
- div_zero  input  1  divisor was zero for this result.
- out_valid  output  1  quot_bcd/rem_bcd/flags valid.
- out_ready  input  1  consumer accepts result.
- quot_bcd  output  40  quotient as 10 packed BCD digits; digit 9 in [39:36].
- rem_bcd  output  40  remainder[31:0] as 10 packed BCD digits.
- rem_ovf  output  1  captured remainder[32] was 1.
- err_dbz  output  1  captured div_zero.
- busy  output  1  high in CONV_Q or CONV_R.

## Operation
- States: IDLE, CONV_Q, CONV_R, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch quotient into shift register, latch remainder[31:0], rem_ovf<=remainder[32], err_dbz<=div_zero, clear BCD accumulator and bit counter; go to CONV_Q.
- CONV_Q: each cycle, every BCD digit ≥5 gets +3, then {bcd,shift} shifts left 1, MSB of the binary shift register entering digit 0 bit 0. Counter 0..31; after 32nd iteration store accumulator into quot_bcd, load remainder[31:0] into shift register, clear accumulator and counter; go to CONV_R.
- CONV_R: identical 32 iterations on remainder; after the 32nd store rem_bcd, go to DONE.
- DONE: out_valid=1; quot_bcd, rem_bcd, rem_ovf, err_dbz held stable. On out_ready go to IDLE.
- Add-3 and shift happen in the same cycle per iteration: correction on current digits, then shift.
- Digits are never ≥10 after an iteration; no carry out of digit 9 (2^32-1 < 10^10).
- rem_ovf and err_dbz affect no computation; conversion runs for every transaction with fixed latency.
- Inputs are sampled only on the accepting edge; later changes are ignored.

## Timing
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, quot_bcd=0, rem_bcd=0, rem_ovf=0, err_dbz=0, counters/shift registers 0. Reset during CONV_Q/CONV_R/DONE discards the transaction; no partial output.
- Accept at edge N; CONV_Q on edges N+1..N+32; CONV_R on edges N+33..N+64; out_valid rises after edge N+64 (64-cycle latency).
- in_ready falls after the accepting edge; busy rises at the same time.
- Output holds indefinitely while out_ready=0.
- Handshake at edge M (out_valid && out_ready): out_valid=0 and in_ready=1 after M. There is no same-cycle accept. The earliest next accept is edge M+1, so throughput is one result per 66 cycles minimum.
- in_valid while busy or in DONE is ignored; the upstream holds it.
- out_ready asserted outside DONE has no effect.
- quot_bcd/rem_bcd keep the previous transaction's values until overwritten at the end of each conversion phase.

## Test plan
- Reset, then quotient=0, remainder=0 -> out_valid after 64 cycles; quot_bcd=0x0000000000, rem_bcd=0x0000000000, flags 0.
- quotient=123456789, remainder=42 -> quot_bcd=0x0123456789, rem_bcd=0x0000000042; in_ready low for exactly 65 cycles with out_ready tied high.
- quotient=32'hFFFFFFFF, remainder=33'h0FFFFFFFE -> quot_bcd=0x4294967295, rem_bcd=0x4294967294.
- remainder=33'h100000007, div_zero=1 -> rem_bcd=0x0000000007, rem_ovf=1, err_dbz=1. A following clean transaction clears both flags.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid with in_valid toggling -> outputs stable, no accept; release -> in_ready=1 next cycle.
- Assert rst at cycle 30 of CONV_Q -> all outputs at reset values immediately. Next transaction (quotient=99, remainder=1) -> 0x0000000099 / 0x0000000001 with full 64-cycle latency.
